hamming_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one Hamming (7,4) encode path between NUM_REQ byte-oriented requesters.
- Each accepted byte is split into two nibbles, low nibble first.
- Each nibble is encoded to a 7-bit codeword and emitted on a single valid/ready output stream, tagged with its source index.
- Sits between the transmit-side clients and the channel serializer.

---
 rtl/hamming_pkg.sv | 21 ++
 rtl/hamming_tx_scheduler_rr_arbiter.sv | 32 +++
 rtl/hamming_tx_scheduler.sv | 141 ++++++++++++++
 tb/tb_hamming_tx_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and the Hamming (7,4) encoder for the codeword transmit scheduler.
package hamming_pkg;

  localparam int CW_W = 7;

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  // Data bits sit at 6,5,4,2; parity bits at 0,1,3.
  function automatic logic [CW_W-1:0] ham74_enc(input logic [3:0] d);
    logic [CW_W-1:0] c;
    c[6] = d[3];
    c[5] = d[2];
    c[4] = d[1];
    c[2] = d[0];
    c[0] = c[6] ^ c[4] ^ c[2];
    c[1] = c[6] ^ c[5] ^ c[2];
    c[3] = c[6] ^ c[5] ^ c[4];
    return c;
  endfunction

endpackage

// File: rtl/hamming_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (modulo NUM_REQ) wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx,
  output logic               any
);

  logic [SRC_W-1:0] pos;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = SRC_W'((int'(ptr) + k) % NUM_REQ);
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        grant_idx  = pos;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hamming_tx_scheduler.sv
// Round-robin byte scheduler feeding one Hamming (7,4) codeword stream, low nibble first.
// Optional error injection for verification is enabled by defining HAMMING_TX_ERR_INJ_EN.
module hamming_tx_scheduler
  import hamming_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef HAMMING_TX_ERR_INJ_EN
  input  logic                 inj_req,
  input  logic [2:0]           inj_pos,
  output logic                 inj_armed,
`endif
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 cw_valid,
  input  logic                 cw_ready,
  output logic [CW_W-1:0]      cw_data,
  output logic [SRC_W-1:0]     cw_src,
  output logic                 cw_last,
  output logic                 busy
);

  state_t           state_q;
  logic [SRC_W-1:0] ptr_q;
  logic [3:0]       hi_q;
  logic             cw_valid_q;
  logic [CW_W-1:0]  cw_data_q;
  logic [SRC_W-1:0] cw_src_q;
  logic             cw_last_q;

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               can_accept;
  logic               accept;
  logic [7:0]         win_byte;
  logic [SRC_W-1:0]   ptr_d;
  logic [CW_W-1:0]    flip_d;
  logic [CW_W-1:0]    cw_lo_d;
  logic [CW_W-1:0]    cw_hi_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_byte = req_data[i*8 +: 8];
    end
  end

  // A new byte can enter while idle, or while the final codeword of the previous byte leaves.
  assign can_accept = (state_q == IDLE) || ((state_q == SEND_HI) && cw_ready);
  assign accept     = can_accept && grant_any && rst_n;
  assign req_ready  = (can_accept && rst_n) ? grant : '0;
  assign ptr_d      = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign cw_lo_d    = ham74_enc(win_byte[3:0]) ^ flip_d;
  assign cw_hi_d    = ham74_enc(hi_q) ^ flip_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hi_q       <= '0;
      cw_valid_q <= 1'b0;
      cw_data_q  <= '0;
      cw_src_q   <= '0;
      cw_last_q  <= 1'b0;
    end else if (accept) begin
      state_q    <= SEND_LO;
      ptr_q      <= ptr_d;
      hi_q       <= win_byte[7:4];
      cw_valid_q <= 1'b1;
      cw_data_q  <= cw_lo_d;
      cw_src_q   <= grant_idx;
      cw_last_q  <= 1'b0;
    end else if ((state_q == SEND_LO) && cw_ready) begin
      state_q   <= SEND_HI;
      cw_data_q <= cw_hi_d;
      cw_last_q <= 1'b1;
    end else if ((state_q == SEND_HI) && cw_ready) begin
      state_q    <= IDLE;
      cw_valid_q <= 1'b0;
      cw_last_q  <= 1'b0;
    end
  end

`ifdef HAMMING_TX_ERR_INJ_EN
  logic       inj_armed_q;
  logic       inj_applied_q;
  logic [2:0] inj_pos_q;
  logic       load;
  logic       hs;
  logic       flip_en;
  logic [2:0] flip_pos;

  assign load     = accept || ((state_q == SEND_LO) && cw_ready);
  assign hs       = cw_valid_q && cw_ready;
  assign flip_pos = inj_req ? inj_pos : inj_pos_q;
  assign flip_en  = load && (inj_req || (inj_armed_q && !inj_applied_q));
  assign flip_d   = (flip_en && (flip_pos != 3'd7)) ? (CW_W'(1) << flip_pos) : '0;

  // applied marks that the word now in the output register carries the flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_armed_q   <= 1'b0;
      inj_applied_q <= 1'b0;
      inj_pos_q     <= '0;
    end else if (inj_req) begin
      inj_armed_q   <= 1'b1;
      inj_pos_q     <= inj_pos;
      inj_applied_q <= load;
    end else if (flip_en) begin
      inj_applied_q <= 1'b1;
    end else if (hs && inj_applied_q) begin
      inj_armed_q   <= 1'b0;
      inj_applied_q <= 1'b0;
    end
  end

  assign inj_armed = inj_armed_q;
`else
  assign flip_d = '0;
`endif

  assign cw_valid = cw_valid_q;
  assign cw_data  = cw_data_q;
  assign cw_src   = cw_src_q;
  assign cw_last  = cw_last_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Scoreboard bench for hamming_tx_scheduler: a word-level model predicts grants and codewords.
module tb_hamming_tx_scheduler;

  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           cw_valid;
  logic           cw_ready;
  logic [6:0]     cw_data;
  logic [SW-1:0]  cw_src;
  logic           cw_last;
  logic           busy;
`ifdef HAMMING_TX_ERR_INJ_EN
  logic           inj_req = 1'b0;
  logic [2:0]     inj_pos = 3'd7;
  logic           inj_armed;
`endif

  always #5 clk = ~clk;

  hamming_tx_scheduler #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef HAMMING_TX_ERR_INJ_EN
    .inj_req   (inj_req),
    .inj_pos   (inj_pos),
    .inj_armed (inj_armed),
`endif
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .cw_src    (cw_src),
    .cw_last   (cw_last),
    .busy      (busy)
  );

  typedef struct packed {
    logic [6:0]    data;
    logic [SW-1:0] src;
    logic          last;
  } cw_t;

  typedef struct {
    int         idx;
    logic [7:0] b;
  } scr_t;

  cw_t        exp_q[$];
  scr_t       scr_q[$];
  int         errors = 0;
  int         checks = 0;
  int         m_pend = 0;
  int         m_ptr  = 0;
  int         m_inj  = -1;
  bit         hold_v[N];
  logic [7:0] hold_d[N];
  bit         rand_en = 1'b0;
  int         rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hamming (7,4): data d3,d2,d1 at 6..4, d0 at 2; parity over the listed data bits.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p0, p1, p3;
    p0 = d[3] ^ d[1] ^ d[0];
    p1 = d[3] ^ d[2] ^ d[0];
    p3 = d[3] ^ d[2] ^ d[1];
    return {d[3], d[2], d[1], p3, d[0], p1, p0};
  endfunction

  // Model: counts codewords still owed; a byte may enter when none or only the last one is leaving.
  always @(negedge clk) begin : model
    int           w;
    bit           allow;
    logic [N-1:0] exp_rr;
    logic [7:0]   b;
    cw_t          e;
    if (!rst_n) begin
      m_pend = 0;
      m_ptr  = 0;
      exp_q.delete();
    end else begin
      check("cw_valid", 32'(cw_valid), 32'(m_pend > 0));
      check("busy", 32'(busy), 32'(m_pend > 0));
      allow = (m_pend == 0) || ((m_pend == 1) && cw_ready);
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      exp_rr = (allow && w >= 0) ? (N'(1) << w) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_rr));
      if (m_pend > 0 && cw_ready) m_pend--;
      if (allow && w >= 0) begin
        b = req_data[w*8 +: 8];
        e.data = enc(b[3:0]);
        if (m_inj >= 0 && m_inj < 7) e.data[m_inj] = ~e.data[m_inj];
        m_inj = -1;
        e.src  = SW'(w);
        e.last = 1'b0;
        exp_q.push_back(e);
        e.data = enc(b[7:4]);
        e.last = 1'b1;
        exp_q.push_back(e);
        m_pend += 2;
        m_ptr = (w + 1) % N;
      end
    end
  end

  always @(negedge clk) begin : monitor
    if (rst_n && cw_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cw_unexpected: got data 0x%0h src %0d, expected no codeword", cw_data, cw_src);
      end else begin
        check("cw_data", 32'(cw_data), 32'(exp_q[0].data));
        check("cw_src", 32'(cw_src), 32'(exp_q[0].src));
        check("cw_last", 32'(cw_last), 32'(exp_q[0].last));
        if (cw_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = hold_v[i];
      req_data[i*8 +: 8]  = hold_d[i];
    end
    cw_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  endtask

  task automatic step();
    bit found;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) hold_v[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!hold_v[i]) begin
        found = 1'b0;
        for (int k = 0; k < scr_q.size(); k++) begin
          if (!found && scr_q[k].idx == i) begin
            hold_v[i] = 1'b1;
            hold_d[i] = scr_q[k].b;
            scr_q.delete(k);
            found = 1'b1;
          end
        end
        if (!found && rand_en && $urandom_range(0, 3) == 0) begin
          hold_v[i] = 1'b1;
          hold_d[i] = 8'($urandom);
        end
      end else if (rand_en && $urandom_range(0, 15) == 0) begin
        hold_v[i] = 1'b0;
      end
    end
    drive();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      hold_v[i] = 1'b0;
      hold_d[i] = 8'h00;
    end
    req_valid = '1;
    req_data  = '0;
    cw_ready  = 1'b1;
    #2;
    check("rst_cw_valid", 32'(cw_valid), 32'd0);
    check("rst_cw_data", 32'(cw_data), 32'd0);
    check("rst_cw_src", 32'(cw_src), 32'd0);
    check("rst_cw_last", 32'(cw_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;

    // single byte from requester 0
    scr_q.push_back('{0, 8'h5B});
    repeat (6) step();

    // back-to-back bytes from requester 2
    scr_q.push_back('{2, 8'h00});
    scr_q.push_back('{2, 8'hFF});
    repeat (8) step();

    // all requesters continuously valid
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) scr_q.push_back('{i, 8'($urandom)});
    end
    repeat (22) step();

    // backpressure during the low codeword
    scr_q.push_back('{1, 8'hA7});
    rdy_mode = 2;
    step();
    scr_q.push_back('{3, 8'h96});
    repeat (5) step();
    rdy_mode = 0;
    repeat (8) step();

    // async reset while the high codeword is waiting
    scr_q.push_back('{1, 8'h3C});
    rdy_mode = 2;
    step();
    step();
    rdy_mode = 0;
    step();
    rdy_mode = 2;
    step();
    check("pre_reset_last", 32'(cw_valid && cw_last), 32'd1);
    for (int i = 0; i < N; i++) begin
      hold_v[i] = 1'b1;
      hold_d[i] = 8'($urandom);
    end
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cw_valid", 32'(cw_valid), 32'd0);
    check("arst_cw_data", 32'(cw_data), 32'd0);
    check("arst_cw_src", 32'(cw_src), 32'd0);
    check("arst_cw_last", 32'(cw_last), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rdy_mode = 0;
    drive();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_grant", 32'(req_ready), 32'd1);
    repeat (12) step();

`ifdef HAMMING_TX_ERR_INJ_EN
    inj_req = 1'b1;
    inj_pos = 3'd2;
    m_inj   = 2;
    step();
    inj_req = 1'b0;
    inj_pos = 3'd7;
    check("inj_armed_set", 32'(inj_armed), 32'd1);
    scr_q.push_back('{0, 8'h0B});
    repeat (3) step();
    check("inj_armed_clear", 32'(inj_armed), 32'd0);
    repeat (4) step();
`endif

    // random traffic, random backpressure, occasional withdrawn requests
    rand_en  = 1'b1;
    rdy_mode = 1;
    repeat (600) step();
    rand_en  = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < N; i++) hold_v[i] = 1'b0;
    scr_q.delete();
    drive();
    for (int t = 0; t < 40 && exp_q.size() > 0; t++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
